// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller for an external dual-port RAM (port A writes, port B reads).
// A show-ahead output stage hides the RAM's registered read latency from the consumer.
module fifo_ctrl #(
    parameter int DATA = 8,
    parameter int ADDR = 4
) (
    input  logic              clK,
    input  logic              rst_N,
    input  logic              wr_VALID,
    output logic              wr_READY,
    input  logic [DATA-1:0]   wr_DATA,
    output logic              rd_VALID,
    input  logic              rd_READY,
    output logic [DATA-1:0]   rd_DATA,
    output logic [ADDR:0]     count,
    output logic              ram_a_WR,
    output logic [ADDR-1:0]   ram_a_ADDR,
    output logic [DATA-1:0]   ram_a_data_IN,
    output logic              ram_b_WR,
    output logic [ADDR-1:0]   ram_b_ADDR,
    input  logic [DATA-1:0]   ram_b_data_OUT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LAND = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ADDR:0] DEPTH_C   = {1'b1, {ADDR{1'b0}}};
    localparam logic [ADDR:0] PTR_ONE_C = {{ADDR{1'b0}}, 1'b1};
    localparam logic [ADDR:0] ZERO_C    = {(ADDR+1){1'b0}};

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR:0]     wptr_r;
    logic [ADDR:0]     rptr_r;
    logic [DATA-1:0]   hold_r;
    logic [DATA-1:0]   hold_nxt_s;
    logic              live_r;
    logic [ADDR:0]     ram_cnt_s;
    logic              wr_ready_s;
    logic              rd_valid_s;
    logic              push_s;
    logic              pop_s;
    logic              fetch_s;

    // Occupancy and handshake qualifiers; the pointer MSB separates full from empty.
    always_comb begin
        ram_cnt_s  = wptr_r - rptr_r;
        wr_ready_s = live_r & (ram_cnt_s != DEPTH_C);
        rd_valid_s = (state_r != IDLE);
        push_s     = wr_VALID & wr_ready_s;
        pop_s      = rd_valid_s & rd_READY;
        fetch_s    = (ram_cnt_s != ZERO_C) & ((state_r == IDLE) | pop_s);
    end

    // Output-stage next state: a fetch always lands; unpopped landed data parks in hold_r.
    always_comb begin
        state_nxt_s = IDLE;
        hold_nxt_s  = hold_r;
        if (fetch_s) begin
            state_nxt_s = LAND;
        end else begin
            case (state_r)
                LAND: begin
                    if (!pop_s) begin
                        state_nxt_s = HOLD;
                        hold_nxt_s  = ram_b_data_OUT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                HOLD: begin
                    if (!pop_s) begin
                        state_nxt_s = HOLD;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Read data mux: RAM output is only valid on the cycle right after the fetch.
    always_comb begin
        rd_DATA = {DATA{1'b0}};
        case (state_r)
            LAND:    rd_DATA = ram_b_data_OUT;
            HOLD:    rd_DATA = hold_r;
            default: rd_DATA = {DATA{1'b0}};
        endcase
    end

    assign wr_READY      = wr_ready_s;
    assign rd_VALID      = rd_valid_s;
    assign count         = ram_cnt_s + {{ADDR{1'b0}}, rd_valid_s};
    assign ram_a_WR      = push_s;
    assign ram_a_ADDR    = wptr_r[ADDR-1:0];
    assign ram_a_data_IN = wr_DATA;
    assign ram_b_WR      = 1'b0;
    assign ram_b_ADDR    = rptr_r[ADDR-1:0];

    // Pointer, output-stage and post-reset enable registers.
    always_ff @(posedge clK or negedge rst_N) begin
        if (!rst_N) begin
            wptr_r  <= ZERO_C;
            rptr_r  <= ZERO_C;
            state_r <= IDLE;
            hold_r  <= {DATA{1'b0}};
            live_r  <= 1'b0;
        end else begin
            live_r  <= 1'b1;
            state_r <= state_nxt_s;
            hold_r  <= hold_nxt_s;
            if (push_s) begin
                wptr_r <= wptr_r + PTR_ONE_C;
            end
            if (fetch_s) begin
                rptr_r <= rptr_r + PTR_ONE_C;
            end
        end
    end

endmodule
